// File: rtl/tff_count_ctrl.sv
// Toggle-vector controller for a synchronous T flip-flop counter bank.
// Mirrors the bank count and publishes t_vec = q ^ q_next ahead of each edge.
module tff_count_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] mod_max,
   input  logic             oneshot,
   input  logic             start,
   input  logic             stop,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] t_vec,
   output logic             tc,
   output logic             busy,
   output logic             done
);

   // state  | meaning
   // IDLE   | stopped, waiting for start (reset state)
   // RUN    | counting on every enabled cycle
   // DONE   | one-shot wrap reached, count held
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_q;
   logic             r_tc;
   logic             r_busy;
   logic             r_done;

   logic             w_step;
   logic             w_up_wrap;
   logic             w_dn_wrap;
   logic             w_dn_clamp;
   logic             w_wrap;
   logic [WIDTH-1:0] w_q_up;
   logic [WIDTH-1:0] w_q_dn;
   logic [WIDTH-1:0] w_q_step;
   logic [WIDTH-1:0] w_q_next;

   // Load and stop both suppress the count step; stop still steers the FSM.
   assign w_step     = (r_state == S_RUN) && en && !load && !stop;

   assign w_up_wrap  = (r_q >= mod_max);
   assign w_dn_wrap  = (r_q == '0);
   assign w_dn_clamp = (r_q > mod_max);

   assign w_q_up     = w_up_wrap ? '0 : (r_q + WIDTH'(1));

   // An out-of-range count pulls back to mod_max going down without a wrap.
   always_comb begin
      w_q_dn = r_q - WIDTH'(1);
      if (w_dn_wrap || w_dn_clamp) begin
         w_q_dn = mod_max;
      end
   end

   assign w_q_step   = up ? w_q_up : w_q_dn;
   assign w_wrap     = w_step && (up ? w_up_wrap : w_dn_wrap);

   always_comb begin
      w_q_next = r_q;
      if (load) begin
         w_q_next = load_val;
      end else if (w_step) begin
         w_q_next = w_q_step;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (!stop && start) begin
               w_state_next = S_RUN;
            end
         end
         S_RUN: begin
            if (stop) begin
               w_state_next = S_IDLE;
            end else if (w_wrap && oneshot) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            if (stop) begin
               w_state_next = S_IDLE;
            end else if (start) begin
               w_state_next = S_RUN;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_q     <= '0;
         r_tc    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_q     <= w_q_next;
         r_tc    <= w_wrap;
         r_busy  <= (w_state_next == S_RUN);
         r_done  <= (w_state_next == S_DONE);
      end
   end

   // Gate on rst so a load strobe during reset cannot toggle the bank.
   assign t_vec = rst ? '0 : (r_q ^ w_q_next);
   assign q     = r_q;
   assign tc    = r_tc;
   assign busy  = r_busy;
   assign done  = r_done;

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Directed bench for tff_count_ctrl: hand-computed count, toggle and status sequences.
module tb_tff_count_ctrl;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en = 1'b0;
   logic         up = 1'b1;
   logic         load = 1'b0;
   logic [W-1:0] load_val = '0;
   logic [W-1:0] mod_max = '0;
   logic         oneshot = 1'b0;
   logic         start = 1'b0;
   logic         stop = 1'b0;
   logic [W-1:0] q;
   logic [W-1:0] t_vec;
   logic         tc;
   logic         busy;
   logic         done;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   tff_count_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
      .mod_max(mod_max), .oneshot(oneshot), .start(start), .stop(stop),
      .q(q), .t_vec(t_vec), .tc(tc), .busy(busy), .done(done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
      mod_max = '0; oneshot = 1'b0; start = 1'b0; stop = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      n_total++; if (q !== 4'd0) $display("FAIL reset_q got %0d exp 0", q); else n_pass++;
      n_total++; if (tc !== 1'b0) $display("FAIL reset_tc got %b exp 0", tc); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
      n_total++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else n_pass++;
      n_total++; if (t_vec !== 4'd0) $display("FAIL reset_tvec got %b exp 0000", t_vec); else n_pass++;
   endtask

   task automatic test_free_run_and_midreset();
      apply_reset();
      mod_max = 4'd9; up = 1'b1; en = 1'b1; oneshot = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      n_total++; if (busy !== 1'b1) $display("FAIL fr_busy got %b exp 1", busy); else n_pass++;
      n_total++; if (q !== 4'd0) $display("FAIL fr_first_q got %0d exp 0", q); else n_pass++;
      for (int k = 1; k <= 10; k++) begin
         #1;
         if (k - 1 == 7) begin
            n_total++; if (t_vec !== 4'b1111) $display("FAIL fr_tvec_q7 got %b exp 1111", t_vec); else n_pass++;
         end
         if (k - 1 == 9) begin
            n_total++; if (t_vec !== 4'b1001) $display("FAIL fr_tvec_q9 got %b exp 1001", t_vec); else n_pass++;
         end
         tick();
         n_total++; if (q !== 4'(k % 10)) $display("FAIL fr_q step %0d got %0d exp %0d", k, q, k % 10); else n_pass++;
         n_total++; if (tc !== (k == 10)) $display("FAIL fr_tc step %0d got %b exp %b", k, tc, (k == 10)); else n_pass++;
      end
      for (int k = 1; k <= 5; k++) tick();
      n_total++; if (q !== 4'd5) $display("FAIL fr_q5 got %0d exp 5", q); else n_pass++;
      #2;
      rst = 1'b1;
      #1;
      n_total++; if (q !== 4'd0) $display("FAIL midrst_q got %0d exp 0", q); else n_pass++;
      n_total++; if (tc !== 1'b0) $display("FAIL midrst_tc got %b exp 0", tc); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b exp 0", busy); else n_pass++;
      n_total++; if (done !== 1'b0) $display("FAIL midrst_done got %b exp 0", done); else n_pass++;
      n_total++; if (t_vec !== 4'd0) $display("FAIL midrst_tvec got %b exp 0000", t_vec); else n_pass++;
      tick();
      rst = 1'b0;
      tick();
      n_total++; if (q !== 4'd0) $display("FAIL postrst_nostep_q got %0d exp 0", q); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL postrst_busy got %b exp 0", busy); else n_pass++;
   endtask

   task automatic test_oneshot_down();
      apply_reset();
      mod_max = 4'd3; up = 1'b0; oneshot = 1'b1; en = 1'b1;
      load = 1'b1; load_val = 4'd2;
      tick();
      load = 1'b0;
      n_total++; if (q !== 4'd2) $display("FAIL os_load_q got %0d exp 2", q); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL os_load_busy got %b exp 0", busy); else n_pass++;
      start = 1'b1;
      tick();
      start = 1'b0;
      n_total++; if (q !== 4'd2 || busy !== 1'b1) $display("FAIL os_start got q=%0d busy=%b exp q=2 busy=1", q, busy); else n_pass++;
      tick();
      n_total++; if (q !== 4'd1) $display("FAIL os_q1 got %0d exp 1", q); else n_pass++;
      tick();
      n_total++; if (q !== 4'd0 || tc !== 1'b0) $display("FAIL os_q0 got q=%0d tc=%b exp q=0 tc=0", q, tc); else n_pass++;
      #1;
      n_total++; if (t_vec !== 4'b0011) $display("FAIL os_tvec_wrap got %b exp 0011", t_vec); else n_pass++;
      tick();
      n_total++; if (q !== 4'd3) $display("FAIL os_wrap_q got %0d exp 3", q); else n_pass++;
      n_total++; if (tc !== 1'b1) $display("FAIL os_wrap_tc got %b exp 1", tc); else n_pass++;
      n_total++; if (done !== 1'b1) $display("FAIL os_wrap_done got %b exp 1", done); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL os_wrap_busy got %b exp 0", busy); else n_pass++;
      tick();
      n_total++; if (q !== 4'd3 || tc !== 1'b0 || done !== 1'b1) $display("FAIL os_hold got q=%0d tc=%b done=%b exp q=3 tc=0 done=1", q, tc, done); else n_pass++;
   endtask

   task automatic test_load_priority();
      apply_reset();
      mod_max = 4'd9; up = 1'b1; en = 1'b1; oneshot = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      load = 1'b1; load_val = 4'd12; stop = 1'b1;
      #1;
      n_total++; if (t_vec !== 4'b1100) $display("FAIL lp_tvec_load got %b exp 1100", t_vec); else n_pass++;
      tick();
      load = 1'b0; stop = 1'b0;
      n_total++; if (q !== 4'd12) $display("FAIL lp_q got %0d exp 12", q); else n_pass++;
      n_total++; if (tc !== 1'b0) $display("FAIL lp_tc got %b exp 0", tc); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL lp_idle_busy got %b exp 0", busy); else n_pass++;
      start = 1'b1;
      tick();
      start = 1'b0;
      n_total++; if (q !== 4'd12 || busy !== 1'b1) $display("FAIL lp_restart got q=%0d busy=%b exp q=12 busy=1", q, busy); else n_pass++;
      #1;
      n_total++; if (t_vec !== 4'b1100) $display("FAIL lp_tvec_wrap got %b exp 1100", t_vec); else n_pass++;
      tick();
      n_total++; if (q !== 4'd0 || tc !== 1'b1) $display("FAIL lp_wrap got q=%0d tc=%b exp q=0 tc=1", q, tc); else n_pass++;
   endtask

   task automatic test_down_clamp();
      apply_reset();
      mod_max = 4'd9; up = 1'b0; en = 1'b1; oneshot = 1'b1;
      load = 1'b1; load_val = 4'd12;
      tick();
      load = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      n_total++; if (q !== 4'd9 || tc !== 1'b0 || busy !== 1'b1) $display("FAIL clamp got q=%0d tc=%b busy=%b exp q=9 tc=0 busy=1", q, tc, busy); else n_pass++;
      tick();
      n_total++; if (q !== 4'd8) $display("FAIL clamp_next got %0d exp 8", q); else n_pass++;
   endtask

   task automatic test_start_stop_and_back_to_back();
      apply_reset();
      mod_max = 4'd0; up = 1'b1; oneshot = 1'b1; en = 1'b1;
      start = 1'b1; stop = 1'b1;
      tick();
      n_total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL ss_conflict got busy=%b done=%b exp 0 0", busy, done); else n_pass++;
      stop = 1'b0;
      tick();
      start = 1'b0;
      n_total++; if (busy !== 1'b1) $display("FAIL ss_start got busy=%b exp 1", busy); else n_pass++;
      tick();
      n_total++; if (q !== 4'd0 || tc !== 1'b1 || done !== 1'b1 || busy !== 1'b0) $display("FAIL ss_mod0_oneshot got q=%0d tc=%b done=%b busy=%b exp 0 1 1 0", q, tc, done, busy); else n_pass++;
      oneshot = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      n_total++; if (busy !== 1'b1 || done !== 1'b0 || tc !== 1'b0) $display("FAIL ss_done_restart got busy=%b done=%b tc=%b exp 1 0 0", busy, done, tc); else n_pass++;
      tick();
      n_total++; if (q !== 4'd0 || tc !== 1'b1) $display("FAIL b2b_first got q=%0d tc=%b exp 0 1", q, tc); else n_pass++;
      tick();
      n_total++; if (tc !== 1'b1 || busy !== 1'b1) $display("FAIL b2b_second got tc=%b busy=%b exp 1 1", tc, busy); else n_pass++;
   endtask

   task automatic test_enable();
      logic en_seq [4];
      int   q_exp  [4];
      en_seq = '{1'b1, 1'b0, 1'b0, 1'b1};
      q_exp  = '{5, 5, 5, 6};
      apply_reset();
      mod_max = 4'd9; up = 1'b1; oneshot = 1'b0; en = 1'b0;
      load = 1'b1; load_val = 4'd4;
      tick();
      load = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      n_total++; if (q !== 4'd4 || busy !== 1'b1) $display("FAIL en_setup got q=%0d busy=%b exp 4 1", q, busy); else n_pass++;
      for (int i = 0; i < 4; i++) begin
         en = en_seq[i];
         #1;
         if (!en_seq[i]) begin
            n_total++; if (t_vec !== 4'd0) $display("FAIL en_tvec cycle %0d got %b exp 0000", i, t_vec); else n_pass++;
         end
         tick();
         n_total++; if (q !== 4'(q_exp[i])) $display("FAIL en_q cycle %0d got %0d exp %0d", i, q, q_exp[i]); else n_pass++;
      end
      n_total++; if (busy !== 1'b1) $display("FAIL en_busy got %b exp 1", busy); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_free_run_and_midreset();
      test_oneshot_down();
      test_load_priority();
      test_down_clamp();
      test_start_stop_and_back_to_back();
      test_enable();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
